// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and MEM.
// Data accesses win; a pending fetch is served after every data access.
module mem_port_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int TO_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_kill,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_done,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          StallF,
  output logic          StallD,
  output logic          StallE,
  output logic          StallM,
  output logic          FlushD,
  output logic          FlushW,
  output logic          bus_err
);

  typedef enum logic [2:0] {
    IDLE,
    IF_BUSY,
    DM_BUSY,
    IF_DONE,
    DM_DONE
  } state_t;

  localparam logic [15:0] ToLast = 16'(TO_CYCLES - 1);

  state_t        state;
  state_t        stateNext;
  logic [15:0]   waitCnt;
  logic          killFlag;
  logic          lastDm;
  logic          busy;
  logic          timeout;
  logic          txnEnd;
  logic          grantDm;
  logic          grantIf;
  logic          dataStall;
  logic          fetchWait;
  logic [DW-1:0] capData;

  assign busy    = (state == IF_BUSY) || (state == DM_BUSY);
  // A ready in the last allowed cycle still counts as a normal completion.
  assign timeout = busy && !mem_ready && (waitCnt == ToLast);
  assign txnEnd  = mem_ready || timeout;
  assign capData = mem_ready ? mem_rdata : '0;
  assign grantDm = dm_req && !(lastDm && if_req);
  assign grantIf = if_req && !grantDm;

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (grantDm) stateNext = DM_BUSY;
        else if (grantIf) stateNext = IF_BUSY;
      end
      IF_BUSY: if (txnEnd) stateNext = IF_DONE;
      DM_BUSY: if (txnEnd) stateNext = DM_DONE;
      IF_DONE: stateNext = IDLE;
      DM_DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      waitCnt   <= '0;
      killFlag  <= 1'b0;
      lastDm    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      state <= stateNext;
      unique case (state)
        IDLE: begin
          waitCnt <= '0;
          if (grantDm) begin
            mem_addr  <= dm_addr;
            mem_we    <= dm_we;
            mem_wdata <= dm_wdata;
          end else if (grantIf) begin
            mem_addr  <= if_addr;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
          end
        end
        IF_BUSY: begin
          killFlag <= killFlag | if_kill;
          if (!mem_ready) waitCnt <= waitCnt + 16'd1;
          if (txnEnd) begin
            if_rdata <= capData;
            lastDm   <= 1'b0;
            mem_we   <= 1'b0;
          end
        end
        DM_BUSY: begin
          if (!mem_ready) waitCnt <= waitCnt + 16'd1;
          if (txnEnd) begin
            dm_rdata <= capData;
            lastDm   <= 1'b1;
            mem_we   <= 1'b0;
          end
        end
        IF_DONE: killFlag <= 1'b0;
        default: ;
      endcase
    end
  end

  assign mem_req  = busy;
  assign bus_err  = timeout;
  assign dm_done  = (state == DM_DONE);
  assign if_valid = (state == IF_DONE) && !killFlag && !if_kill;

  // MEM-stage stalls dominate; a fetch wait only bubbles decode.
  assign dataStall = dm_req && (state != DM_DONE);
  assign fetchWait = !dataStall && if_req && !if_valid;

  assign StallF = dataStall || fetchWait;
  assign StallD = dataStall;
  assign StallE = dataStall;
  assign StallM = dataStall;
  assign FlushW = dataStall;
  assign FlushD = fetchWait;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed transaction table, reset corner
// cases and random transactions checked against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_kill, if_valid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we, dm_done;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          mem_req, mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          StallF, StallD, StallE, StallM, FlushD, FlushW, bus_err;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TO_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushW(FlushW), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          dmOn;
    bit          ifOn;
    bit          we;
    logic [31:0] dAddr;
    logic [31:0] iAddr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    int          killAt;
    int          dropAt;
    bit          expDm;
    int          expBusy;
    bit          expErr;
    bit          expValid;
    logic [31:0] expRdata;
  } txn_t;

  int nChk = 0;
  int nFail = 0;
  bit lastDm = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chkB(input string name, input logic act, input logic exp);
    chk(name, 32'(act), 32'(exp));
  endtask

  function automatic logic [5:0] expStall(bit dmReq, bit ifReq,
                                          bit inDmDone, bit ifVal);
    bit ds;
    bit fw;
    ds = dmReq && !inDmDone;
    fw = !ds && ifReq && !ifVal;
    return {ds | fw, ds, ds, ds, fw, ds};
  endfunction

  task automatic chkStall(input string name, input logic [5:0] exp);
    chk(name, 32'({StallF, StallD, StallE, StallM, FlushD, FlushW}),
        32'(exp));
  endtask

  // Transaction-level prediction: who wins, how long, what comes back.
  function automatic txn_t predict(txn_t t);
    bit toHit;
    toHit      = t.waits >= TO;
    t.expDm    = t.dmOn && !(lastDm && t.ifOn);
    t.expBusy  = toHit ? TO : t.waits + 1;
    t.expErr   = toHit;
    t.expRdata = toHit ? 32'h0 : t.rdata;
    t.expValid = !(t.killAt >= 0 && t.killAt <= t.expBusy);
    return t;
  endfunction

  task automatic idleInputs();
    if_req = 0; if_kill = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    mem_ready = 0; mem_rdata = '0;
  endtask

  task automatic runTxn(input txn_t t, input string tag);
    logic [31:0] expAddr;
    expAddr = t.expDm ? t.dAddr : t.iAddr;
    @(negedge clk);
    dm_req = t.dmOn; if_req = t.ifOn; dm_we = t.we;
    dm_addr = t.dAddr; dm_wdata = t.wdata; if_addr = t.iAddr;
    if_kill = 0; mem_ready = 0; mem_rdata = t.rdata;
    #1;
    chkB({tag, " grant mem_req"}, mem_req, 1'b0);
    chkStall({tag, " grant stall"}, expStall(t.dmOn, t.ifOn, 0, 0));
    for (int k = 0; k < t.expBusy; k++) begin
      @(negedge clk);
      if (k == t.dropAt) begin
        dm_req = 0;
        if_req = 0;
      end
      if_kill = (k == t.killAt);
      mem_ready = (k == t.waits);
      #1;
      chkB({tag, " busy mem_req"}, mem_req, 1'b1);
      chk({tag, " busy mem_addr"}, mem_addr, expAddr);
      chkB({tag, " busy mem_we"}, mem_we, t.expDm && t.we);
      if (t.expDm && t.we)
        chk({tag, " busy mem_wdata"}, mem_wdata, t.wdata);
      chkB({tag, " busy bus_err"}, bus_err,
           t.expErr && (k == t.expBusy - 1));
      chkB({tag, " busy done"}, dm_done | if_valid, 1'b0);
      chkStall({tag, " busy stall"}, expStall(dm_req, if_req, 0, 0));
    end
    @(negedge clk);
    if_kill = (t.killAt == t.expBusy);
    mem_ready = 0;
    #1;
    chkB({tag, " done mem_req"}, mem_req, 1'b0);
    chkB({tag, " done bus_err"}, bus_err, 1'b0);
    chkB({tag, " dm_done"}, dm_done, t.expDm);
    chkB({tag, " if_valid"}, if_valid, !t.expDm && t.expValid);
    if (t.expDm)
      chk({tag, " dm_rdata"}, dm_rdata, t.expRdata);
    else if (t.expValid)
      chk({tag, " if_rdata"}, if_rdata, t.expRdata);
    chkStall({tag, " done stall"},
             expStall(dm_req, if_req, t.expDm, !t.expDm && t.expValid));
    lastDm = t.expDm;
    @(negedge clk);
    idleInputs();
    #1;
    chkB({tag, " idle mem_req"}, mem_req, 1'b0);
    chkB({tag, " idle pulses"}, dm_done | if_valid | bus_err, 1'b0);
    chkStall({tag, " idle stall"}, 6'b0);
  endtask

  function automatic txn_t mk(bit dmOn, bit ifOn, bit we,
                              logic [31:0] dA, logic [31:0] iA,
                              logic [31:0] wd, logic [31:0] rd, int w,
                              int kill, int drop, bit eDm, int eBusy,
                              bit eErr, bit eVal, logic [31:0] eRd);
    txn_t t;
    t.dmOn = dmOn; t.ifOn = ifOn; t.we = we;
    t.dAddr = dA; t.iAddr = iA; t.wdata = wd; t.rdata = rd;
    t.waits = w; t.killAt = kill; t.dropAt = drop;
    t.expDm = eDm; t.expBusy = eBusy; t.expErr = eErr;
    t.expValid = eVal; t.expRdata = eRd;
    return t;
  endfunction

  txn_t vec[12];

  initial begin
    vec[0]  = mk(0, 1, 0, 32'h0, 32'h10, 32'h0, 32'h0050_0093, 0, -1, -1,
                 0, 1, 0, 1, 32'h0050_0093);
    vec[1]  = mk(1, 1, 0, 32'h200, 32'h20, 32'h0, 32'h1111_2222, 1, -1, -1,
                 1, 2, 0, 0, 32'h1111_2222);
    vec[2]  = mk(1, 1, 0, 32'h200, 32'h20, 32'h0, 32'h3333_4444, 0, -1, -1,
                 0, 1, 0, 1, 32'h3333_4444);
    vec[3]  = mk(1, 0, 0, 32'h100, 32'h0, 32'h0, 32'hDEAD_BEEF, 3, -1, -1,
                 1, 4, 0, 0, 32'hDEAD_BEEF);
    vec[4]  = mk(1, 0, 1, 32'h104, 32'h0, 32'h1234_5678, 32'hCAFE_F00D, 2,
                 -1, -1, 1, 3, 0, 0, 32'hCAFE_F00D);
    vec[5]  = mk(0, 1, 0, 32'h0, 32'h30, 32'h0, 32'h0000_0013, 2, 1, -1,
                 0, 3, 0, 0, 32'h0000_0013);
    vec[6]  = mk(0, 1, 0, 32'h0, 32'h40, 32'h0, 32'h00A0_0513, 0, -1, -1,
                 0, 1, 0, 1, 32'h00A0_0513);
    vec[7]  = mk(1, 0, 0, 32'h300, 32'h0, 32'h0, 32'h5555_5555, 9, -1, -1,
                 1, 4, 1, 0, 32'h0);
    vec[8]  = mk(0, 1, 0, 32'h0, 32'h50, 32'h0, 32'h6666_6666, 9, -1, -1,
                 0, 4, 1, 1, 32'h0);
    vec[9]  = mk(0, 1, 0, 32'h0, 32'h60, 32'h0, 32'h7777_0000, 0, 1, -1,
                 0, 1, 0, 0, 32'h7777_0000);
    vec[10] = mk(1, 0, 0, 32'h400, 32'h0, 32'h0, 32'h7777_8888, 2, -1, 0,
                 1, 3, 0, 0, 32'h7777_8888);
    vec[11] = mk(1, 0, 0, 32'h404, 32'h0, 32'h0, 32'h9999_AAAA, 0, 0, -1,
                 1, 1, 0, 0, 32'h9999_AAAA);

    rst = 1'b1;
    idleInputs();
    repeat (2) @(negedge clk);
    #1;
    chkB("reset mem_req", mem_req, 1'b0);
    chkB("reset mem_we", mem_we, 1'b0);
    chkB("reset pulses", if_valid | dm_done | bus_err, 1'b0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset mem_wdata", mem_wdata, 32'h0);
    chk("reset if_rdata", if_rdata, 32'h0);
    chk("reset dm_rdata", dm_rdata, 32'h0);
    chkStall("reset stall", 6'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++)
      runTxn(vec[i], $sformatf("vec%0d", i));

    // Reset in the middle of a store: request must vanish asynchronously.
    @(negedge clk);
    dm_req = 1; dm_we = 1; dm_addr = 32'h500; dm_wdata = 32'hA5A5_5A5A;
    @(negedge clk);
    #1;
    chkB("rstseq busy mem_req", mem_req, 1'b1);
    rst = 1'b1;
    #1;
    chkB("rstseq async mem_req", mem_req, 1'b0);
    chkB("rstseq async mem_we", mem_we, 1'b0);
    chk("rstseq async mem_addr", mem_addr, 32'h0);
    chk("rstseq async dm_rdata", dm_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idleInputs();
    lastDm = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #1;
      chkB("rstseq no completion", dm_done | if_valid | mem_req, 1'b0);
    end

    // Reset while a fetch is marked killed: the kill must not survive.
    @(negedge clk);
    if_req = 1; if_addr = 32'h80;
    @(negedge clk);
    if_kill = 1;
    @(negedge clk);
    if_kill = 0;
    #1;
    rst = 1'b1;
    #1;
    chkB("killrst mem_req", mem_req, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idleInputs();
    runTxn(mk(0, 1, 0, 32'h0, 32'h84, 32'h0, 32'h0010_0073, 1, -1, -1,
              0, 2, 0, 1, 32'h0010_0073), "killrst");

    for (int n = 0; n < 150; n++) begin
      txn_t t;
      int sel;
      sel = int'($urandom_range(0, 2));
      t.dmOn = (sel != 0);
      t.ifOn = (sel != 1);
      t.we = 1'($urandom_range(0, 1));
      t.dAddr = $urandom & 32'hFFFF_FFFC;
      t.iAddr = $urandom & 32'hFFFF_FFFC;
      t.wdata = $urandom;
      t.rdata = $urandom;
      t.waits = int'($urandom_range(0, 6));
      t.killAt = -1;
      t.dropAt = -1;
      t = predict(t);
      if ($urandom_range(0, 3) == 0)
        t.killAt = int'($urandom_range(0, 32'(t.expBusy)));
      if ($urandom_range(0, 4) == 0)
        t.dropAt = int'($urandom_range(0, 32'(t.expBusy - 1)));
      t = predict(t);
      runTxn(t, $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChk, nFail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port instruction/data memory between the fetch stage (IF) and the memory stage (MEM) of the 5-stage RISC-V pipeline.
- Sequences the memory handshake and generates pipeline stall/flush requests.
- The top level ORs these requests with the hazard unit's StallF/StallD/FlushD/FlushE.
- Data accesses have priority. After a data access completes, a pending fetch is granted next.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TO_CYCLES, 255, maximum cycles waiting for mem_ready before the transaction is abandoned (1..2^16-1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch wants the instruction at if_addr.
- if_addr  in  AW  PC of the fetch.
- if_kill  in  1  redirect (PCSrcE); the in-flight fetch result is discarded.
- if_valid  out  1  instruction on if_rdata is valid this cycle.
- if_rdata  out  DW  fetched instruction (registered).
- dm_req  in  1  MEM-stage load/store pending.
- dm_we  in  1  1 = store.
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  store data.
- dm_done  out  1  data access complete this cycle.
- dm_rdata  out  DW  load data (registered).
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid when mem_ready = 1.
- mem_ready  in  1  memory accepts/completes the request this cycle.
- StallF, StallD, StallE, StallM  out  1 each  pipeline register holds.
- FlushD  out  1  bubble into the D stage (fetch not ready).
- FlushW  out  1  bubble into the WB stage (MEM stalled).
- bus_err  out  1  one-cycle pulse on timeout.

Behaviour:
- States: IDLE, IF_BUSY, DM_BUSY, IF_DONE, DM_DONE.
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - Outputs cleared: mem_req, mem_we, if_valid, dm_done, bus_err.
  - mem_addr, mem_wdata, if_rdata, dm_rdata all go to 0.
  - Wait counter cleared; internal kill flag and last_dm flag cleared.
  - Reset during a transaction abandons it with no completion pulse.
- IDLE arbitration:
  - dm_req=1 goes to DM_BUSY, except when last_dm=1 and if_req=1, which goes to IF_BUSY.
  - Otherwise if_req=1 goes to IF_BUSY.
  - The address, write enable and write data of the granted requester are latched into mem_addr, mem_we and mem_wdata at the grant edge.
  - last_dm is set when a DM transaction completes and cleared when an IF transaction completes.
- BUSY states:
  - mem_req=1 for every cycle in the state.
  - mem_addr, mem_we and mem_wdata are held stable until mem_ready is sampled high.
  - On mem_ready, mem_rdata is captured into dm_rdata or if_rdata, and the state moves to DM_DONE or IF_DONE.
  - The memory may assert mem_ready in the first mem_req cycle, so minimum latency is grant edge, then one cycle to DONE.
- DONE states:
  - Each lasts exactly one cycle with mem_req=0, then returns to IDLE.
  - DM_DONE: dm_done=1.
  - IF_DONE: if_valid=1, unless the kill flag is set.
- if_kill:
  - Asserted while IF_BUSY: sets the kill flag, the transaction still completes, and if_valid is suppressed in IF_DONE. The flag clears in IF_DONE.
  - Asserted in IF_DONE: suppresses if_valid in the same cycle.
  - Asserted in IDLE or DM_*: has no effect.
- Stall outputs (combinational from state and inputs):
  - Data stall, when dm_req=1 and state != DM_DONE: StallF, StallD, StallE and StallM are all 1, FlushW=1, FlushD=0.
  - Fetch wait, when no data stall and if_req=1 and if_valid=0: StallF=1, FlushD=1, all other outputs 0.
  - dm_req=1 always wins over fetch wait.
  - A load therefore stalls MEM for at least 2 cycles: the grant cycle and the BUSY cycle with immediate ready.
- Timeout:
  - A 16-bit wait counter is cleared on entry to a BUSY state and increments each BUSY cycle while mem_ready=0.
  - When the counter reaches TO_CYCLES, bus_err pulses for 1 cycle, mem_req drops, and the state goes to DM_DONE or IF_DONE.
  - In that DONE state the captured data is 0; dm_done and if_valid behave as on a normal completion.
- Simultaneous mem_ready and timeout in the same cycle: mem_ready wins and bus_err stays 0.
- Request drop mid-transaction: if_req or dm_req falling in a BUSY state does not abort the transaction; it completes normally.

Test Plan:
- Fetch only, mem_ready tied 1, if_addr=0x0000_0010, mem_rdata=0x0050_0093:
  - mem_req is high 1 cycle with mem_addr=0x10.
  - The next cycle has if_valid=1 and if_rdata=0x0050_0093.
  - StallF=FlushD=1 during the grant and BUSY cycles.
- Load with 3 wait states, dm_addr=0x100, mem_rdata=0xDEAD_BEEF:
  - StallF/D/E/M=1 and FlushW=1 for 5 cycles.
  - dm_done=1 with dm_rdata=0xDEADBEEF in cycle 6, with all stalls 0.
- dm_req and if_req together in IDLE with last_dm=0:
  - The DM transaction is granted first.
  - The next IDLE grants IF even though dm_req is still high.
- Store dm_we=1, dm_wdata=0x1234_5678:
  - mem_we=1 and mem_wdata=0x12345678 held stable over 2 wait cycles.
  - dm_done pulses once.
- if_kill pulsed during IF_BUSY with mem_ready delayed 2 cycles:
  - IF_DONE occurs with if_valid=0.
  - The following fetch to the new if_addr=0x40 returns if_valid=1.
- TO_CYCLES=4 with mem_ready held 0:
  - bus_err pulses on the 4th BUSY wait cycle and mem_req drops.
  - dm_done=1 with dm_rdata=0.
  - rst asserted mid-BUSY in a separate run drops mem_req immediately, without waiting for a clock edge.
